// File: rtl/decode_operand_stage_pkg.sv
// Shared definitions for the decode operand stage: widths, stage state
// encoding, control bundle field offsets and the ID/EX register record.
// Optional build macro used by this slice: DECODE_PERF_EN.
package decode_operand_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int CTRL_W = 8;

    // Last action taken by the stage.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } stage_state_e;

    // Field offsets inside the opaque EX/MEM/WB control bundle.
    localparam int CTRL_ALUOP_LSB    = 0;
    localparam int CTRL_ALUOP_W      = 3;
    localparam int CTRL_ALUSRC_BIT   = 3;
    localparam int CTRL_MEMWRITE_BIT = 4;
    localparam int CTRL_BRANCH_BIT   = 5;
    localparam int CTRL_JUMP_BIT     = 6;
    localparam int CTRL_MEMTOREG_BIT = 7;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] wreg;
        logic              regwrite;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
    } ex_pkt_t;

    // Same-cycle writeback wins over the (not yet updated) register file.
    function automatic logic [DATA_W-1:0] bypass(
        input logic              wr,
        input logic [REG_AW-1:0] wsel,
        input logic [REG_AW-1:0] rsel,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] rdata
    );
        return (wr && (wsel == rsel)) ? wdata : rdata;
    endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Bus bundle of the decode operand stage: IF/ID inputs, register file
// read port, writeback bypass, EX handshake and the ID/EX outputs.
// With DECODE_PERF_EN the hold/bubble counters ride on the same bundle.
interface decode_operand_stage_if
    import decode_operand_stage_pkg::*;
();
    logic              if_valid;
    logic [REG_AW-1:0] if_rs, if_rt, if_rd;
    logic              if_uses_rs, if_uses_rt;
    logic              if_regwrite, if_memread;
    logic [DATA_W-1:0] if_imm, if_pc;
    logic [CTRL_W-1:0] if_ctrl;
    logic [REG_AW-1:0] rf_read1sel, rf_read2sel;
    logic [DATA_W-1:0] rf_read1data, rf_read2data;
    logic              wb_write;
    logic [REG_AW-1:0] wb_regsel;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              ex_ready;
    logic              stall_out;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm, ex_pc;
    logic [REG_AW-1:0] ex_wreg;
    logic              ex_regwrite, ex_memread;
    logic [CTRL_W-1:0] ex_ctrl;
`ifdef DECODE_PERF_EN
    logic [15:0]       perf_bubbles, perf_holds;
`endif

    // Surrounding pipeline / test driver view.
    modport master (
        output if_valid, if_rs, if_rt, if_rd, if_uses_rs, if_uses_rt,
               if_regwrite, if_memread, if_imm, if_pc, if_ctrl,
               rf_read1data, rf_read2data, wb_write, wb_regsel, wb_data,
               flush, ex_ready,
        input  rf_read1sel, rf_read2sel, stall_out, ex_valid, ex_a, ex_b,
               ex_imm, ex_pc, ex_wreg, ex_regwrite, ex_memread, ex_ctrl
`ifdef DECODE_PERF_EN
        , input perf_bubbles, perf_holds
`endif
    );

    // Decode stage view.
    modport slave (
        input  if_valid, if_rs, if_rt, if_rd, if_uses_rs, if_uses_rt,
               if_regwrite, if_memread, if_imm, if_pc, if_ctrl,
               rf_read1data, rf_read2data, wb_write, wb_regsel, wb_data,
               flush, ex_ready,
        output rf_read1sel, rf_read2sel, stall_out, ex_valid, ex_a, ex_b,
               ex_imm, ex_pc, ex_wreg, ex_regwrite, ex_memread, ex_ctrl
`ifdef DECODE_PERF_EN
        , output perf_bubbles, perf_holds
`endif
    );

endinterface

// File: rtl/decode_operand_stage_ld_use_detect.sv
// Load-use hazard detector: the instruction in IF/ID consumes the result
// of a load still sitting in EX, whose data is not yet available.
module ld_use_detect
    import decode_operand_stage_pkg::*;
(
    input  logic              if_valid,
    input  logic [REG_AW-1:0] if_rs,
    input  logic [REG_AW-1:0] if_rt,
    input  logic              if_uses_rs,
    input  logic              if_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_wreg,
    output logic              haz
);

    logic rs_hit, rt_hit;

    // R0 is a real register, so no zero-register exemption here.
    always_comb begin
        rs_hit = if_uses_rs && (if_rs == ex_wreg);
        rt_hit = if_uses_rt && (if_rt == ex_wreg);
        haz    = if_valid && ex_valid && ex_memread && ex_regwrite && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode-stage operand fetch and ID/EX pipeline register.
// Reads the register file, bypasses the same-cycle writeback, bubbles on
// load-use, holds on EX backpressure and drops the EX slot on flush.
// Optional: DECODE_PERF_EN adds saturating hold/bubble entry counters.
module decode_operand_stage
    import decode_operand_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    decode_operand_stage_if.slave  bus
);

    ex_pkt_t           ex_q, ex_d;
    stage_state_e      state_q, state_d;
    logic              haz;
    logic              stall;
    logic [DATA_W-1:0] op_a, op_b;

    assign bus.rf_read1sel = bus.if_rs;
    assign bus.rf_read2sel = bus.if_rt;

    // Operand select: writeback of this cycle overrides the register file.
    always_comb begin
        op_a = bypass(bus.wb_write, bus.wb_regsel, bus.if_rs, bus.wb_data, bus.rf_read1data);
        op_b = bypass(bus.wb_write, bus.wb_regsel, bus.if_rt, bus.wb_data, bus.rf_read2data);
    end

    ld_use_detect u_ld_use (
        .if_valid    (bus.if_valid),
        .if_rs       (bus.if_rs),
        .if_rt       (bus.if_rt),
        .if_uses_rs  (bus.if_uses_rs),
        .if_uses_rt  (bus.if_uses_rt),
        .ex_valid    (ex_q.valid),
        .ex_memread  (ex_q.memread),
        .ex_regwrite (ex_q.regwrite),
        .ex_wreg     (ex_q.wreg),
        .haz         (haz)
    );

    // Action select, priority flush > hold > bubble > issue.
    always_comb begin
        ex_d    = ex_q;
        state_d = ST_RUN;
        stall   = 1'b0;
        if (bus.flush) begin
            ex_d.valid = 1'b0;
        end else if (!bus.ex_ready) begin
            stall   = 1'b1;
            state_d = ST_HOLD;
        end else if (haz) begin
            ex_d.valid    = 1'b0;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
            stall         = 1'b1;
            state_d       = ST_BUBBLE;
        end else begin
            ex_d.valid    = bus.if_valid;
            ex_d.a        = op_a;
            ex_d.b        = op_b;
            ex_d.imm      = bus.if_imm;
            ex_d.pc       = bus.if_pc;
            ex_d.wreg     = bus.if_rd;
            ex_d.regwrite = bus.if_regwrite;
            ex_d.memread  = bus.if_memread;
            ex_d.ctrl     = bus.if_ctrl;
        end
    end

    // ID/EX register and last-action state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            state_q <= ST_RUN;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
        end
    end

    assign bus.stall_out   = stall;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_a        = ex_q.a;
    assign bus.ex_b        = ex_q.b;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_wreg     = ex_q.wreg;
    assign bus.ex_regwrite = ex_q.regwrite;
    assign bus.ex_memread  = ex_q.memread;
    assign bus.ex_ctrl     = ex_q.ctrl;

`ifdef DECODE_PERF_EN
    logic [15:0] perf_bubbles_q, perf_holds_q;

    // Count entries (not residency) into BUBBLE / HOLD, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubbles_q <= '0;
            perf_holds_q   <= '0;
        end else begin
            if (state_d == ST_BUBBLE && state_q != ST_BUBBLE && perf_bubbles_q != 16'hFFFF)
                perf_bubbles_q <= perf_bubbles_q + 16'd1;
            if (state_d == ST_HOLD && state_q != ST_HOLD && perf_holds_q != 16'hFFFF)
                perf_holds_q <= perf_holds_q + 16'd1;
        end
    end

    assign bus.perf_bubbles = perf_bubbles_q;
    assign bus.perf_holds   = perf_holds_q;
`endif

    // A bubble leaves EX empty, so the stalled instruction cannot re-hazard.
    a_bubble_clears: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ST_BUBBLE) |-> (!ex_q.valid && !haz));

    // A hold keeps the downstream stages frozen via stall.
    a_hold_stalls: assert property (@(posedge clk) disable iff (!rst)
        (!bus.flush && !bus.ex_ready) |-> stall);

endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench for decode_operand_stage: directed scenarios then
// random traffic, every cycle checked against an EX-slot reference model.
module tb_decode_operand_stage;
    import decode_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_operand_stage_if bus ();

    decode_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file model, written by writeback at the clock edge.
    logic [15:0] regs [8];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'(i) * 16'h0101;
        end else if (bus.wb_write) begin
            regs[bus.wb_regsel] <= bus.wb_data;
        end
    end
    assign bus.rf_read1data = regs[bus.if_rs];
    assign bus.rf_read2data = regs[bus.if_rt];

    typedef struct {
        logic        valid;
        logic [2:0]  rs, rt, rd;
        logic        urs, urt, rw, mr;
        logic [15:0] imm, pc;
        logic [7:0]  ctrl;
        logic        wbw;
        logic [2:0]  wbr;
        logic [15:0] wbd;
        logic        flush, ready;
    } stim_t;

    typedef struct {
        logic        stall;
        logic [2:0]  rs, rt;
        logic        v;
        logic [15:0] a, b, imm, pc;
        logic [2:0]  wreg;
        logic        rw, mr;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t  sb [$];
    exp_t  m;
    stim_t prev;
    logic  prev_stall = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    pushed = 0;
    int    checked = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t base();
        stim_t s;
        s.valid = 1'b0; s.rs = 3'd0; s.rt = 3'd0; s.rd = 3'd0;
        s.urs = 1'b0; s.urt = 1'b0; s.rw = 1'b0; s.mr = 1'b0;
        s.imm = 16'h0; s.pc = 16'h0; s.ctrl = 8'h0;
        s.wbw = 1'b0; s.wbr = 3'd0; s.wbd = 16'h0;
        s.flush = 1'b0; s.ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.valid = ($urandom_range(0, 99) < 85);
        s.rs    = 3'($urandom_range(0, 7));
        s.rt    = 3'($urandom_range(0, 7));
        s.rd    = 3'($urandom_range(0, 7));
        s.urs   = ($urandom_range(0, 99) < 75);
        s.urt   = ($urandom_range(0, 99) < 60);
        s.mr    = ($urandom_range(0, 99) < 35);
        s.rw    = s.mr ? 1'b1 : 1'($urandom_range(0, 1));
        s.imm   = 16'($urandom);
        s.pc    = 16'($urandom);
        s.ctrl  = 8'($urandom);
        s.wbw   = ($urandom_range(0, 99) < 40);
        s.wbr   = 3'($urandom_range(0, 7));
        s.wbd   = 16'($urandom);
        s.flush = ($urandom_range(0, 99) < 8);
        s.ready = ($urandom_range(0, 99) < 80);
        return s;
    endfunction

    // Value an instruction sees for register r: this cycle's writeback if it targets r.
    function automatic logic [15:0] value_of(input stim_t s, input logic [2:0] r);
        if (s.wbw && s.wbr == r) return s.wbd;
        return regs[r];
    endfunction

    // Apply one cycle of stimulus and predict the stall and the EX slot after the edge.
    task automatic drive(input stim_t s);
        exp_t e;
        logic needs_load;
        @(negedge clk);
        rst             = 1'b1;
        bus.if_valid    = s.valid;
        bus.if_rs       = s.rs;
        bus.if_rt       = s.rt;
        bus.if_rd       = s.rd;
        bus.if_uses_rs  = s.urs;
        bus.if_uses_rt  = s.urt;
        bus.if_regwrite = s.rw;
        bus.if_memread  = s.mr;
        bus.if_imm      = s.imm;
        bus.if_pc       = s.pc;
        bus.if_ctrl     = s.ctrl;
        bus.wb_write    = s.wbw;
        bus.wb_regsel   = s.wbr;
        bus.wb_data     = s.wbd;
        bus.flush       = s.flush;
        bus.ex_ready    = s.ready;
        // EX holds a live load whose destination this instruction reads.
        needs_load = s.valid && m.v && m.mr && m.rw &&
                     ((s.urs && s.rs == m.wreg) || (s.urt && s.rt == m.wreg));
        e = m;
        e.rs = s.rs;
        e.rt = s.rt;
        if (s.flush) begin
            e.stall = 1'b0;
            e.v     = 1'b0;
        end else if (!s.ready) begin
            e.stall = 1'b1;
        end else if (needs_load) begin
            e.stall = 1'b1;
            e.v = 1'b0; e.rw = 1'b0; e.mr = 1'b0;
        end else begin
            e.stall = 1'b0;
            e.v = s.valid;
            e.a = value_of(s, s.rs);
            e.b = value_of(s, s.rt);
            e.imm = s.imm; e.pc = s.pc; e.wreg = s.rd;
            e.rw = s.rw; e.mr = s.mr; e.ctrl = s.ctrl;
        end
        sb.push_back(e);
        pushed++;
        m = e;
        prev = s;
        prev_stall = e.stall;
    endtask

    // Monitor: stall/selects mid-cycle, EX register just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            chk("stall_out",   16'(bus.stall_out),   16'(e.stall));
            chk("rf_read1sel", 16'(bus.rf_read1sel), 16'(e.rs));
            chk("rf_read2sel", 16'(bus.rf_read2sel), 16'(e.rt));
            @(posedge clk);
            #1;
            chk("ex_valid",    16'(bus.ex_valid),    16'(e.v));
            chk("ex_a",        bus.ex_a,             e.a);
            chk("ex_b",        bus.ex_b,             e.b);
            chk("ex_imm",      bus.ex_imm,           e.imm);
            chk("ex_pc",       bus.ex_pc,            e.pc);
            chk("ex_wreg",     16'(bus.ex_wreg),     16'(e.wreg));
            chk("ex_regwrite", 16'(bus.ex_regwrite), 16'(e.rw));
            chk("ex_memread",  16'(bus.ex_memread),  16'(e.mr));
            chk("ex_ctrl",     16'(bus.ex_ctrl),     16'(e.ctrl));
            checked++;
        end
    end

    initial begin : stimulus
        stim_t s, s2;
        m = '{stall: 1'b0, rs: 3'd0, rt: 3'd0, v: 1'b0, a: 16'h0, b: 16'h0,
              imm: 16'h0, pc: 16'h0, wreg: 3'd0, rw: 1'b0, mr: 1'b0, ctrl: 8'h0};
        prev = base();

        // Reset with a valid instruction waiting: EX must stay empty.
        s = rnd_stim();
        bus.if_valid = 1'b1; bus.if_rs = s.rs; bus.if_rt = s.rt; bus.if_rd = s.rd;
        bus.if_uses_rs = 1'b1; bus.if_uses_rt = 1'b1; bus.if_regwrite = 1'b1;
        bus.if_memread = 1'b1; bus.if_imm = s.imm; bus.if_pc = s.pc; bus.if_ctrl = s.ctrl;
        bus.wb_write = 1'b1; bus.wb_regsel = s.wbr; bus.wb_data = s.wbd;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset ex_valid", 16'(bus.ex_valid),  16'h0);
            chk("reset ex_a",     bus.ex_a,           16'h0);
            chk("reset stall",    16'(bus.stall_out), 16'h0);
        end

        // First instruction after release lands in EX one clock later.
        s = base(); s.valid = 1'b1; s.rs = 3'd1; s.rt = 3'd2; s.rd = 3'd4;
        s.urs = 1'b1; s.urt = 1'b1; s.rw = 1'b1; s.imm = 16'h1234; s.pc = 16'h0002; s.ctrl = 8'h5A;
        drive(s);

        // Writeback bypass: R3 = 0x1111 in the file, 0xBEEF written this cycle.
        s = base(); s.wbw = 1'b1; s.wbr = 3'd3; s.wbd = 16'h1111;
        drive(s);
        s = base(); s.valid = 1'b1; s.rs = 3'd3; s.urs = 1'b1; s.rd = 3'd1; s.rw = 1'b1;
        s.wbw = 1'b1; s.wbr = 3'd3; s.wbd = 16'hBEEF;
        drive(s);

        // Load-use on rt: one stall, one bubble, then the add issues with bypassed data.
        s = base(); s.valid = 1'b1; s.rd = 3'd2; s.rw = 1'b1; s.mr = 1'b1; s.pc = 16'h0010;
        drive(s);
        s = base(); s.valid = 1'b1; s.rs = 3'd1; s.rt = 3'd2; s.urs = 1'b1; s.urt = 1'b1;
        s.rd = 3'd5; s.rw = 1'b1; s.pc = 16'h0012;
        drive(s);
        s.wbw = 1'b1; s.wbr = 3'd2; s.wbd = 16'hCAFE;
        drive(s);

        // Same pair, but rt is not read: no stall.
        s = base(); s.valid = 1'b1; s.rd = 3'd2; s.rw = 1'b1; s.mr = 1'b1;
        drive(s);
        s = base(); s.valid = 1'b1; s.rs = 3'd1; s.rt = 3'd2; s.urs = 1'b1; s.urt = 1'b0;
        s.rd = 3'd5; s.rw = 1'b1;
        drive(s);

        // Hold: ex_a = 0x0042 survives two not-ready cycles, then next is captured.
        s = base(); s.valid = 1'b1; s.rs = 3'd6; s.urs = 1'b1; s.rd = 3'd7;
        s.wbw = 1'b1; s.wbr = 3'd6; s.wbd = 16'h0042;
        drive(s);
        s2 = base(); s2.valid = 1'b1; s2.rs = 3'd0; s2.rt = 3'd7; s2.urs = 1'b1; s2.urt = 1'b1;
        s2.rd = 3'd0; s2.rw = 1'b1; s2.imm = 16'h00FF; s2.pc = 16'h0020; s2.ready = 1'b0;
        drive(s2);
        drive(s2);
        s2.ready = 1'b1;
        drive(s2);

        // Flush beats hold and hazard in the same cycle.
        s = base(); s.valid = 1'b1; s.rd = 3'd5; s.rw = 1'b1; s.mr = 1'b1;
        drive(s);
        s = base(); s.valid = 1'b1; s.rs = 3'd5; s.urs = 1'b1; s.ready = 1'b0; s.flush = 1'b1;
        drive(s);

        // Random traffic; a stalled IF/ID keeps presenting the same instruction.
        for (int n = 0; n < 600; n++) begin
            s = rnd_stim();
            if (prev_stall) begin
                s.valid = prev.valid; s.rs = prev.rs; s.rt = prev.rt; s.rd = prev.rd;
                s.urs = prev.urs; s.urt = prev.urt; s.rw = prev.rw; s.mr = prev.mr;
                s.imm = prev.imm; s.pc = prev.pc; s.ctrl = prev.ctrl;
            end
            drive(s);
        end

        for (int w = 0; w < 10 && checked != pushed; w++) @(posedge clk);
        #2;
        if (checked != pushed) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: checked %0d of %0d pushed", checked, pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
